mem_blkmove: RTL and testbench



---
 rtl/blk_pkg.sv | 36 +++
 rtl/blk_agen.sv | 61 ++++++
 rtl/mem_blkmove.sv | 217 +++++++++++++++++++++
 tb/tb_mem_blkmove.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blk_pkg.sv
// -----------------------------------------------------------------------------
// blk_pkg
//
// Shared definitions for the mem_blkmove block-transfer engine.
//
// Contents:
//   ASZ     - default memory word-address width (32K words)
//   DSZ     - default memory data width
//   op_t    - command opcode (MOVE = word copy, FILL = pattern fill)
//   state_t - engine FSM states
// -----------------------------------------------------------------------------
package blk_pkg;

  localparam int ASZ = 15;
  localparam int DSZ = 32;

  // Encoding matches the core-side `op` strobe: 0 = MOVE, 1 = FILL.
  typedef enum logic {
    MOVE = 1'b0,
    FILL = 1'b1
  } op_t;

  // IDLE : waiting for start
  // RD   : MOVE read phase (source address on the bus)
  // WR   : MOVE write phase (read data written to destination)
  // FL   : FILL write, one word per cycle
  // DONE : one-cycle completion pulse
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    FL   = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage : blk_pkg

// File: rtl/blk_agen.sv
// -----------------------------------------------------------------------------
// blk_agen
//
// Loadable up/down word-address counter. The count direction is captured at
// load time and held for the whole command; arithmetic wraps modulo 2^AW, so
// the top address steps to 0 going up and 0 steps to the top address going
// down.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   load       in   capture load_addr / load_down (has priority over step)
//   load_addr  in   start address for the new command
//   load_down  in   1 = decrement on each step, 0 = increment
//   step       in   advance the address by one word
//   addr       out  current address
// -----------------------------------------------------------------------------
module blk_agen #(
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] load_addr,
  input  logic          load_down,
  input  logic          step,
  output logic [AW-1:0] addr
);

  logic [AW-1:0] addr_q, addr_d;
  logic          down_q, down_d;

  // NOTE: every signal written in a combinational block gets a default on the
  // first lines; a path that leaves one unassigned would infer a latch.
  always_comb begin
    addr_d = addr_q;
    down_d = down_q;
    if (load) begin
      addr_d = load_addr;
      down_d = load_down;
    end else if (step) begin
      // Natural AW-bit overflow provides the wrap in both directions.
      addr_d = down_q ? addr_q - AW'(1) : addr_q + AW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      down_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      down_q <= down_d;
    end
  end

  assign addr = addr_q;

endmodule : blk_agen

// File: rtl/mem_blkmove.sv
// -----------------------------------------------------------------------------
// mem_blkmove
//
// Bus-master block-transfer engine in front of a single-port word memory.
// Executes word copy (overlap-safe, like CMOVE) and pattern fill (FILL) without
// core involvement. One command at a time via start / busy / done.
//
// Command (sampled only in IDLE when start = 1):
//   op   0 = MOVE, 1 = FILL
//   src  MOVE source word address
//   dst  destination word address
//   len  word count, 0 .. 2^ASZ
//   pat  FILL pattern
//   msk  byte mask applied to every write
//
// Status:
//   busy  high while a command is transferring (RD/WR/FL)
//   done  one-cycle pulse when the command completes
//
// Memory bus (combinational from state registers, sampled by the memory at
// the end of each cycle):
//   ai    word address
//   we    write enable
//   vi    write data
//   bmsk  byte mask
//   vo    read data, valid the cycle after a read address is presented
//
// Timing: MOVE takes 2 cycles per word (read, then write), FILL 1 cycle per
// word. done is high in the cycle ending 2*len+1 (MOVE), len+1 (FILL) or 1
// (len = 0) edges after the start edge.
// -----------------------------------------------------------------------------
module mem_blkmove #(
  parameter int ASZ = blk_pkg::ASZ,
  parameter int DSZ = blk_pkg::DSZ
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           op,
  input  logic [ASZ-1:0] src,
  input  logic [ASZ-1:0] dst,
  input  logic [ASZ:0]   len,
  input  logic [DSZ-1:0] pat,
  input  logic [3:0]     msk,
  output logic           busy,
  output logic           done,
  output logic [ASZ-1:0] ai,
  output logic           we,
  output logic [DSZ-1:0] vi,
  output logic [3:0]     bmsk,
  input  logic [DSZ-1:0] vo
);

  import blk_pkg::*;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t         state_q, state_d;
  logic [ASZ:0]   cnt_q,   cnt_d;    // words remaining
  logic [DSZ-1:0] pat_q,   pat_d;    // latched fill pattern
  logic [3:0]     msk_q,   msk_d;    // latched byte mask, drives bmsk directly
  logic [ASZ-1:0] ai_q,    ai_d;     // last bus address, held in IDLE/DONE
  logic [DSZ-1:0] vi_q,    vi_d;     // last bus write data, held when idle

  // ---------------------------------------------------------------------------
  // Command decode (only meaningful in IDLE with start = 1)
  // ---------------------------------------------------------------------------
  logic           cmd_accept;
  logic           cmd_nonzero;
  logic           cmd_down;
  logic [ASZ-1:0] cmd_diff;
  logic [ASZ-1:0] cmd_last_off;      // len - 1, modulo 2^ASZ
  logic [ASZ-1:0] src_start;
  logic [ASZ-1:0] dst_start;
  logic           agen_load;

  assign cmd_accept  = (state_q == IDLE) && start;
  assign cmd_nonzero = (len != '0);
  assign cmd_diff    = dst - src;

  // A forward copy would overwrite source words before reading them when the
  // destination starts inside the source block above src. Copying from the top
  // down avoids that smear. FILL has no source and always ascends.
  assign cmd_down = (op_t'(op) == MOVE) && (dst > src) &&
                    ({1'b0, cmd_diff} < len);

  // len = 2^ASZ has a zero low field, which wraps to the all-ones offset as
  // required for a full-memory block.
  assign cmd_last_off = len[ASZ-1:0] - ASZ'(1);
  assign src_start    = cmd_down ? src + cmd_last_off : src;
  assign dst_start    = cmd_down ? dst + cmd_last_off : dst;

  // ---------------------------------------------------------------------------
  // Address generators
  // ---------------------------------------------------------------------------
  logic [ASZ-1:0] src_addr;
  logic [ASZ-1:0] dst_addr;
  logic           src_step;
  logic           dst_step;

  assign agen_load = cmd_accept && cmd_nonzero;
  assign src_step  = (state_q == WR);
  assign dst_step  = (state_q == WR) || (state_q == FL);

  blk_agen #(.AW(ASZ)) u_src_agen (
    .clk       (clk),
    .rst       (rst),
    .load      (agen_load),
    .load_addr (src_start),
    .load_down (cmd_down),
    .step      (src_step),
    .addr      (src_addr)
  );

  blk_agen #(.AW(ASZ)) u_dst_agen (
    .clk       (clk),
    .rst       (rst),
    .load      (agen_load),
    .load_addr (dst_start),
    .load_down (cmd_down),
    .step      (dst_step),
    .addr      (dst_addr)
  );

  // ---------------------------------------------------------------------------
  // Next-state and bus outputs
  // ---------------------------------------------------------------------------
  logic last_word;
  assign last_word = (cnt_q == (ASZ+1)'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    msk_d   = msk_q;
    ai      = ai_q;
    vi      = vi_q;
    we      = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          pat_d = pat;
          msk_d = msk;
          cnt_d = len;
          if (!cmd_nonzero)            state_d = DONE;
          else if (op_t'(op) == FILL)  state_d = FL;
          else                         state_d = RD;
        end
      end

      RD: begin
        busy    = 1'b1;
        ai      = src_addr;
        state_d = WR;
      end

      WR: begin
        busy    = 1'b1;
        ai      = dst_addr;
        we      = 1'b1;
        vi      = vo;
        cnt_d   = cnt_q - (ASZ+1)'(1);
        state_d = last_word ? DONE : RD;
      end

      FL: begin
        busy    = 1'b1;
        ai      = dst_addr;
        we      = 1'b1;
        vi      = pat_q;
        cnt_d   = cnt_q - (ASZ+1)'(1);
        state_d = last_word ? DONE : FL;
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    ai_d = ai;
    vi_d = vi;
  end

  assign bmsk = msk_q;

  // ---------------------------------------------------------------------------
  // Registers. Reset drops busy/we combinationally because it clears state_q
  // asynchronously, so nothing more is written once rst rises.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      msk_q   <= 4'b1111;
      ai_q    <= '0;
      vi_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      msk_q   <= msk_d;
      ai_q    <= ai_d;
      vi_q    <= vi_d;
    end
  end

endmodule : mem_blkmove

// File: tb/tb_mem_blkmove.sv
// -----------------------------------------------------------------------------
// tb_mem_blkmove
//
// Self-checking bench for mem_blkmove. A behavioural 32K x 32 byte-masked
// memory sits on the bus. Each command pushes its expected write sequence
// (address, data, mask in order) onto a queue; a monitor pops and compares on
// every observed write. Completion latency and final memory contents are
// checked after each command.
// -----------------------------------------------------------------------------
module tb_mem_blkmove;

  localparam int ASZ = 15;
  localparam int DSZ = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           op;
  logic [ASZ-1:0] src;
  logic [ASZ-1:0] dst;
  logic [ASZ:0]   len;
  logic [DSZ-1:0] pat;
  logic [3:0]     msk;
  logic           busy;
  logic           done;
  logic [ASZ-1:0] ai;
  logic           we;
  logic [DSZ-1:0] vi;
  logic [3:0]     bmsk;
  logic [DSZ-1:0] vo;

  always #5 clk = ~clk;

  mem_blkmove #(.ASZ(ASZ), .DSZ(DSZ)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .src   (src),
    .dst   (dst),
    .len   (len),
    .pat   (pat),
    .msk   (msk),
    .busy  (busy),
    .done  (done),
    .ai    (ai),
    .we    (we),
    .vi    (vi),
    .bmsk  (bmsk),
    .vo    (vo)
  );

  // ---------------------------------------------------------------------------
  // Memory model: registered read, byte-masked write at the clock edge.
  // ---------------------------------------------------------------------------
  logic [DSZ-1:0] mem [0:(1<<ASZ)-1];
  logic [DSZ-1:0] vo_r;
  assign vo = vo_r;

  always @(posedge clk) begin
    vo_r <= mem[ai];
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (bmsk[b]) mem[ai][8*b +: 8] = vi[8*b +: 8];
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  typedef struct packed {
    logic [ASZ-1:0] addr;
    logic [DSZ-1:0] data;
    logic [3:0]     msk;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  // Every write on the bus must match the next expected write.
  always @(negedge clk) begin
    if (!rst && we) begin
      check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(ai),   32'(mon_e.addr));
        check("wr_data", vi,        mon_e.data);
        check("wr_bmsk", 32'(bmsk), 32'(mon_e.msk));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Expected-write generators
  // ---------------------------------------------------------------------------
  task automatic push_fill(input logic [ASZ-1:0] d, input int n,
                           input logic [DSZ-1:0] p, input logic [3:0] m);
    wr_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = d + ASZ'(i);
      e.data = p;
      e.msk  = m;
      exp_q.push_back(e);
    end
  endtask

  // Data comes from a snapshot of the source taken now, i.e. memmove
  // semantics; the order follows the overlap rule.
  task automatic push_move(input logic [ASZ-1:0] s, input logic [ASZ-1:0] d,
                           input int n, input logic [3:0] m);
    wr_t            e;
    logic [ASZ-1:0] diff;
    bit             down;
    int             i;
    diff = d - s;
    down = (d > s) && (int'(diff) < n);
    for (int k = 0; k < n; k++) begin
      i      = down ? (n - 1 - k) : k;
      e.addr = d + ASZ'(i);
      e.data = mem[s + ASZ'(i)];
      e.msk  = m;
      exp_q.push_back(e);
    end
  endtask

  // Issue one command, scramble the inputs afterwards, wait for done.
  task automatic run_cmd(input string tag, input logic o,
                         input logic [ASZ-1:0] s, input logic [ASZ-1:0] d,
                         input logic [ASZ:0] n, input logic [DSZ-1:0] p,
                         input logic [3:0] m, input int exp_lat);
    int lat;
    @(negedge clk);
    start = 1'b1; op = o; src = s; dst = d; len = n; pat = p; msk = m;
    @(posedge clk);
    #1;
    start = 1'b0;
    op  = 1'($urandom);  src = ASZ'($urandom); dst = ASZ'($urandom);
    len = (ASZ+1)'($urandom); pat = $urandom; msk = 4'($urandom);
    lat = 0;
    for (int c = 1; c <= 2 * int'(n) + 20; c++) begin
      @(negedge clk);
      if (c == 1) check({tag, "_busy"}, 32'(busy), 32'(n != 0));
      if (done) begin
        lat = c;
        break;
      end
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    check({tag, "_qempty"}, exp_q.size(), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int lat2;

  initial begin
    rst = 1'b1; start = 1'b0; op = 1'b0; src = '0; dst = '0; len = '0;
    pat = '0; msk = '0;
    for (int i = 0; i < (1 << ASZ); i++) mem[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we",   32'(we),   32'd0);
    check("rst_ai",   32'(ai),   32'd0);
    check("rst_vi",   vi,        32'd0);
    check("rst_bmsk", 32'(bmsk), 32'hf);
    @(negedge clk);
    rst = 1'b0;

    // FILL basic
    mem[15'h14] = 32'h1111_1111;
    push_fill(15'h10, 4, 32'hdeadbeef, 4'hf);
    run_cmd("fill", 1'b1, 15'h0, 15'h10, 16'd4, 32'hdeadbeef, 4'hf, 5);
    check("fill_ai_hold", 32'(ai), 32'h13);
    check("fill_we_done", 32'(we), 32'd0);
    for (int i = 0; i < 4; i++) check("fill_mem", mem[15'h10 + 15'(i)], 32'hdeadbeef);
    check("fill_mem_after", mem[15'h14], 32'h1111_1111);

    // MOVE forward, disjoint
    for (int i = 0; i < 8; i++) begin
      mem[15'h100 + 15'(i)] = i;
      mem[15'h200 + 15'(i)] = 32'hcccc_cccc;
    end
    push_move(15'h100, 15'h200, 8, 4'hf);
    run_cmd("mv_fwd", 1'b0, 15'h100, 15'h200, 16'd8, 32'h0, 4'hf, 17);
    for (int i = 0; i < 8; i++) check("mv_fwd_mem", mem[15'h200 + 15'(i)], i);

    // MOVE overlapping, dst above src: must descend
    for (int i = 0; i < 8; i++) mem[15'h100 + 15'(i)] = i;
    push_move(15'h100, 15'h102, 6, 4'hf);
    run_cmd("mv_down", 1'b0, 15'h100, 15'h102, 16'd6, 32'h0, 4'hf, 13);
    for (int i = 0; i < 6; i++) check("mv_down_mem", mem[15'h102 + 15'(i)], i);

    // MOVE overlapping, dst below src: ascends
    for (int i = 0; i < 8; i++) mem[15'h100 + 15'(i)] = i;
    push_move(15'h102, 15'h100, 6, 4'hf);
    run_cmd("mv_up", 1'b0, 15'h102, 15'h100, 16'd6, 32'h0, 4'hf, 13);
    for (int i = 0; i < 6; i++) check("mv_up_mem", mem[15'h100 + 15'(i)], i + 2);

    // FILL across the address wrap
    mem[15'h0002] = 32'h0bad_0bad;
    push_fill(15'h7ffe, 4, 32'h5a5a5a5a, 4'hf);
    run_cmd("fill_wrap", 1'b1, 15'h0, 15'h7ffe, 16'd4, 32'h5a5a5a5a, 4'hf, 5);
    check("wrap_7ffe", mem[15'h7ffe], 32'h5a5a5a5a);
    check("wrap_7fff", mem[15'h7fff], 32'h5a5a5a5a);
    check("wrap_0000", mem[15'h0000], 32'h5a5a5a5a);
    check("wrap_0001", mem[15'h0001], 32'h5a5a5a5a);
    check("wrap_0002", mem[15'h0002], 32'h0bad_0bad);

    // MOVE across the wrap, descending overlap
    for (int i = 0; i < 4; i++) mem[15'h7ffd + 15'(i)] = 32'h70 + i;
    push_move(15'h7ffd, 15'h7fff, 4, 4'hf);
    run_cmd("mv_wrap", 1'b0, 15'h7ffd, 15'h7fff, 16'd4, 32'h0, 4'hf, 9);
    for (int i = 0; i < 4; i++) check("mv_wrap_mem", mem[15'h7fff + 15'(i)], 32'h70 + i);

    // Byte mask
    mem[15'h20] = 32'hffff_ffff;
    push_fill(15'h20, 1, 32'h0, 4'b0011);
    run_cmd("mask", 1'b1, 15'h0, 15'h20, 16'd1, 32'h0, 4'b0011, 2);
    check("mask_mem", mem[15'h20], 32'hffff_0000);

    // Zero length: no writes (monitor flags any), done after one cycle
    run_cmd("len0_fill", 1'b1, 15'h0, 15'h30, 16'd0, 32'h1234_5678, 4'hf, 1);
    run_cmd("len0_move", 1'b0, 15'h100, 15'h30, 16'd0, 32'h0, 4'hf, 1);

    // start while busy is ignored
    mem[15'h600] = 32'h6666_6666;
    push_fill(15'h500, 4, 32'h0000_0500, 4'hf);
    @(negedge clk);
    start = 1'b1; op = 1'b1; dst = 15'h500; len = 16'd4; pat = 32'h0000_0500; msk = 4'hf;
    @(posedge clk);
    #1;
    dst = 15'h600; len = 16'd2; pat = 32'h0000_0600; src = 15'h100; op = 1'b0;
    lat2 = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 3) start = 1'b0;
      if (done) begin
        lat2 = c;
        break;
      end
    end
    check("busy_start_lat", lat2, 5);
    repeat (6) @(negedge clk);
    check("busy_start_q", exp_q.size(), 0);
    check("busy_start_600", mem[15'h600], 32'h6666_6666);
    for (int i = 0; i < 4; i++) check("busy_start_mem", mem[15'h500 + 15'(i)], 32'h0000_0500);

    // Reset mid-MOVE
    for (int i = 0; i < 8; i++) begin
      mem[15'h300 + 15'(i)] = 32'h30 + i;
      mem[15'h400 + 15'(i)] = 32'heeee_eeee;
    end
    push_move(15'h300, 15'h400, 8, 4'hf);
    @(negedge clk);
    start = 1'b1; op = 1'b0; src = 15'h300; dst = 15'h400; len = 16'd8; msk = 4'hf;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_we",   32'(we),   32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_mid_400", mem[15'h400], 32'h30);
    check("rst_mid_401", mem[15'h401], 32'h31);
    check("rst_mid_402", mem[15'h402], 32'heeee_eeee);
    check("rst_mid_407", mem[15'h407], 32'heeee_eeee);
    check("rst_mid_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_blkmove
